// File: rtl/risc5_intc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc5_intc_pkg
// Description : Shared definitions for the RISC5 interrupt controller:
//               register indices, FSM state encoding, STATUS bit positions
//               and the vector-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package risc5_intc_pkg;

    // Register indices on the IO bus
    localparam logic [2:0] REG_ENABLE  = 3'd0;
    localparam logic [2:0] REG_PENDING = 3'd1;
    localparam logic [2:0] REG_EDGE    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_OVF     = 3'd4;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // STATUS register bit positions
    localparam int STATUS_VALID_BIT = 31;
    localparam int STATUS_INSVC_BIT = 30;

    // Vector width: enough bits to index NSRC sources, never less than one
    function automatic int f_vw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int NSRC_DEFAULT = 8;
    localparam int VW_DEFAULT   = f_vw(NSRC_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/risc5_intc_prio.sv
`default_nettype none
// ============================================================================
// Module      : risc5_intc_prio
// Description : Fixed-priority encoder, lowest set index wins.
//               i_mask : NSRC request mask
//               o_any  : at least one bit of i_mask is set
//               o_idx  : index of the lowest set bit (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module risc5_intc_prio #(
    parameter int NSRC = 8,
    parameter int VW   = 3
) (
    input  logic [NSRC-1:0] i_mask,
    output logic            o_any,
    output logic [VW-1:0]   o_idx
);

    always_comb begin
        o_any = |i_mask;
        o_idx = '0;
        // Scan from the top so the lowest set index is written last
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_idx = VW'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/risc5_intc.sv
`default_nettype none
// ============================================================================
// Module      : risc5_intc
// Description : NSRC-channel interrupt controller for the RISC5 core.
//               Per-channel enable and edge/level mode, fixed priority
//               (lowest index wins), one irq line to the CPU, vector latched
//               on int_ack, in-service held until EOI (STATUS write) or rti.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               irq_in[NSRC]    - source request lines
//               irq             - request to the CPU
//               int_ack, rti    - CPU acknowledge / return-from-interrupt
//               rd, wr, adr,
//               wdata, rdata    - register bus (rdata combinational)
//               vec, in_service - latched vector, SERVICE-state flag
// Options     : RISC5_INTC_OVF_EN - adds the sticky per-channel overflow
//               register at index 4 (reads 0 otherwise)
// Revision    : 1.0 - initial release
// ============================================================================
module risc5_intc
    import risc5_intc_pkg::*;
#(
    parameter  int NSRC = 8,
    localparam int VW   = f_vw(NSRC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_in,
    output logic            irq,
    input  logic            int_ack,
    input  logic            rti,
    input  logic            rd,
    input  logic            wr,
    input  logic [2:0]      adr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [VW-1:0]   vec,
    output logic            in_service
);

    logic [NSRC-1:0] r_irq_q;
    logic [NSRC-1:0] r_irq_prev;
    logic [NSRC-1:0] r_enable;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_pend;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nx;
    logic [VW-1:0]   r_vec;
    logic            r_valid;

    logic [NSRC-1:0] w_wdata;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_pend_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_ovf_rd;
    logic            w_any;
    logic [VW-1:0]   w_idx;
    logic            w_ack;
    logic            w_eoi;

    assign w_wdata = wdata[NSRC-1:0];

    generate
        if (NSRC < 32) begin : g_unused_wdata
            logic w_unused_hi;
            assign w_unused_hi = ^wdata[31:NSRC];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input stage and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q    <= '0;
            r_irq_prev <= '0;
        end else begin
            r_irq_q    <= irq_in;
            r_irq_prev <= r_irq_q;
        end
    end

    assign w_rise = r_irq_q & ~r_irq_prev;

    // ------------------------------------------------------------------
    // Request selection (uses registered enable, so a same-cycle ENABLE
    // write does not affect an acknowledge)
    // ------------------------------------------------------------------
    risc5_intc_prio #(
        .NSRC (NSRC),
        .VW   (VW)
    ) u_prio (
        .i_mask (r_pend & r_enable),
        .o_any  (w_any),
        .o_idx  (w_idx)
    );

    assign w_ack      = (r_state == ST_REQ) && int_ack;
    assign w_eoi      = (wr && (adr == REG_STATUS)) || rti;
    assign w_pend_w1c = (wr && (adr == REG_PENDING)) ? w_wdata : '0;

    always_comb begin
        w_ack_clr = '0;
        if (w_ack && w_any) begin
            w_ack_clr[w_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Configuration and pending registers
    // Edge channels: set on rise (set beats clear), cleared by W1C or ack.
    // Level channels: mirror irq_q, never cleared by the controller.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_enable <= '0;
            r_edge   <= '0;
            r_pend   <= '0;
        end else begin
            if (wr && (adr == REG_ENABLE)) begin
                r_enable <= w_wdata;
            end
            if (wr && (adr == REG_EDGE)) begin
                r_edge <= w_wdata;
            end
            r_pend <= (r_edge & ((r_pend & ~w_pend_w1c & ~w_ack_clr) | w_rise))
                    | (~r_edge & r_irq_q);
        end
    end

`ifdef RISC5_INTC_OVF_EN
    logic [NSRC-1:0] r_ovf;
    logic [NSRC-1:0] w_ovf_w1c;

    assign w_ovf_w1c = (wr && (adr == REG_OVF)) ? w_wdata : '0;

    // A fresh edge on an edge channel whose pending bit is still set
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~w_ovf_w1c) | (r_edge & w_rise & r_pend);
        end
    end

    assign w_ovf_rd = r_ovf;
`else
    assign w_ovf_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Controller FSM
    // IDLE is always occupied for at least one cycle with irq low, so the
    // CPU's edge detector sees a fresh rising edge for every request.
    // Once in REQ, irq stays high until ack even if the request vanishes.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nx = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_state_nx = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (w_eoi) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Vector latch: a spurious ack (nothing left to serve) records vec=0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec   <= '0;
            r_valid <= 1'b0;
        end else if (w_ack) begin
            r_valid <= w_any;
            r_vec   <= w_any ? w_idx : '0;
        end else if ((r_state == ST_SERVICE) && w_eoi) begin
            r_valid <= 1'b0;
            r_vec   <= '0;
        end
    end

    assign irq        = (r_state == ST_REQ);
    assign in_service = (r_state == ST_SERVICE);
    assign vec        = r_vec;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        if (rd) begin
            case (adr)
                REG_ENABLE:  rdata[NSRC-1:0] = r_enable;
                REG_PENDING: rdata[NSRC-1:0] = r_pend;
                REG_EDGE:    rdata[NSRC-1:0] = r_edge;
                REG_STATUS: begin
                    rdata[STATUS_VALID_BIT] = r_valid;
                    rdata[STATUS_INSVC_BIT] = in_service;
                    rdata[VW-1:0]           = r_vec;
                end
                REG_OVF:     rdata[NSRC-1:0] = w_ovf_rd;
                default:     rdata = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_risc5_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc5_intc
// Description : Self-checking bench for risc5_intc (NSRC=8). Expected
//               vectors are queued when a request is stimulated and popped
//               when the controller is acknowledged.
// Options     : RISC5_INTC_OVF_EN - expects the overflow register to be live
// Revision    : 1.0 - initial release
// ============================================================================
module tb_risc5_intc;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_in;
    logic        irq;
    logic        int_ack;
    logic        rti;
    logic        rd;
    logic        wr;
    logic [2:0]  adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  vec;
    logic        in_service;

    int checks   = 0;
    int failures = 0;

    logic [2:0] sb_q[$];

`ifdef RISC5_INTC_OVF_EN
    localparam logic [31:0] EXP_OVF = 32'h0000_0040;
`else
    localparam logic [31:0] EXP_OVF = 32'h0000_0000;
`endif

    risc5_intc #(.NSRC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq        (irq),
        .int_ack    (int_ack),
        .rti        (rti),
        .rd         (rd),
        .wr         (wr),
        .adr        (adr),
        .wdata      (wdata),
        .rdata      (rdata),
        .vec        (vec),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bus / timing helpers (no checking here) ----------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        wr = 1'b1; adr = a; wdata = d;
        tick();
        wr = 1'b0; wdata = '0;
    endtask

    task automatic rd_reg(input logic [2:0] a, output logic [31:0] d);
        rd = 1'b1; adr = a;
        #1;
        d = rdata;
        rd = 1'b0;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse(input int ch);
        irq_in[ch] = 1'b1;
        tick();
        irq_in[ch] = 1'b0;
    endtask

    task automatic wait_irq(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- tests ---------------------------------------------
    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (irq !== 1'b0 || in_service !== 1'b0 || vec !== 3'd0) begin
            failures++;
            $display("FAIL reset_outputs irq=%b in_service=%b vec=%0d required 0/0/0", irq, in_service, vec);
        end
        checks++;
        if (rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata_idle got=%h required=0", rdata);
        end
        rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            rd_reg(3'(a), d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h required=0", a, d);
            end
        end
        tick();
    endtask

    task automatic test_edge_basic();
        logic [31:0] d;
        logic [2:0]  e;
        wr_reg(3'd0, 32'h08);
        wr_reg(3'd2, 32'h08);
        tick();
        sb_q.push_back(3'd3);
        pulse(3);                // irq_in high during one cycle
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL edge_lat1 irq=%b required=0", irq); end
        tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL edge_lat2 irq=%b required=0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL edge_lat3 irq=%b required=1", irq); end
        do_ack();
        e = sb_q.pop_front();
        checks++;
        if (vec !== e || in_service !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL edge_ack vec=%0d in_service=%b irq=%b required vec=%0d 1/0", vec, in_service, irq, e);
        end
        rd_reg(3'd3, d);
        checks++;
        if ((d & 32'h8000_0007) !== 32'h8000_0003) begin
            failures++;
            $display("FAIL edge_status got=%h required valid+vec=80000003", d);
        end
        checks++;
        if (d[30] !== 1'b1) begin failures++; $display("FAIL edge_status_insvc got=%b required=1", d[30]); end
        rd_reg(3'd1, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL edge_pending got=%h required=0", d); end
        wr_reg(3'd3, 32'h0);
        rd_reg(3'd3, d);
        checks++;
        if (d !== 32'h0 || in_service !== 1'b0) begin
            failures++;
            $display("FAIL edge_eoi status=%h in_service=%b required 0/0", d, in_service);
        end
        tick(); tick();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL edge_after_eoi irq=%b required=0", irq); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        logic [2:0]  e;
        bit ok;
        wr_reg(3'd0, 32'hFF);
        wr_reg(3'd2, 32'hFF);
        sb_q.push_back(3'd2);
        sb_q.push_back(3'd5);
        irq_in = 8'b0010_0100;
        tick();
        irq_in = 8'h00;
        wait_irq(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL prio_wait1 irq=%b required=1", irq); end
        do_ack();
        e = sb_q.pop_front();
        checks++;
        if (vec !== e) begin failures++; $display("FAIL prio_vec1 got=%0d required=%0d", vec, e); end
        rd_reg(3'd1, d);
        checks++;
        if (d !== 32'h20) begin failures++; $display("FAIL prio_pending got=%h required=20", d); end
        rti = 1'b1;              // EOI and rti together act as one EOI
        wr_reg(3'd3, 32'h0);
        rti = 1'b0;
        checks++;
        if (irq !== 1'b0 || in_service !== 1'b0) begin
            failures++;
            $display("FAIL prio_idle_gap irq=%b in_service=%b required 0/0", irq, in_service);
        end
        tick();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL prio_rerequest irq=%b required=1", irq); end
        do_ack();
        e = sb_q.pop_front();
        checks++;
        if (vec !== e) begin failures++; $display("FAIL prio_vec2 got=%0d required=%0d", vec, e); end
        rti = 1'b1;
        tick();
        rti = 1'b0;
    endtask

    task automatic test_level();
        logic [31:0] d;
        logic [2:0]  e;
        bit ok;
        bit seen;
        wr_reg(3'd2, 32'h00);
        wr_reg(3'd0, 32'h02);
        sb_q.push_back(3'd1);
        irq_in[1] = 1'b1;
        wait_irq(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL level_wait irq=%b required=1", irq); end
        do_ack();
        e = sb_q.pop_front();
        checks++;
        if (vec !== e) begin failures++; $display("FAIL level_vec1 got=%0d required=%0d", vec, e); end
        rd_reg(3'd1, d);
        checks++;
        if (d !== 32'h02) begin failures++; $display("FAIL level_pending got=%h required=02", d); end
        wr_reg(3'd3, 32'h0);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL level_idle irq=%b required=0", irq); end
        tick();
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL level_rereq irq=%b required=1", irq); end
        sb_q.push_back(3'd1);
        do_ack();
        e = sb_q.pop_front();
        checks++;
        if (vec !== e) begin failures++; $display("FAIL level_vec2 got=%0d required=%0d", vec, e); end
        irq_in[1] = 1'b0;
        tick(); tick();
        wr_reg(3'd3, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (irq !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL level_dropped irq_seen=1 required=0"); end
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        logic [2:0]  e;
        bit ok;
        wr_reg(3'd2, 32'h10);
        wr_reg(3'd0, 32'h10);
        sb_q.push_back(3'd0);
        pulse(4);
        wait_irq(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL spur_wait irq=%b required=1", irq); end
        wr_reg(3'd1, 32'h10);
        rd_reg(3'd1, d);
        checks++;
        if (irq !== 1'b1 || d !== 32'h0) begin
            failures++;
            $display("FAIL spur_hold irq=%b pending=%h required 1/0", irq, d);
        end
        do_ack();
        e = sb_q.pop_front();
        rd_reg(3'd3, d);
        checks++;
        if (d[31] !== 1'b0 || vec !== e || in_service !== 1'b1) begin
            failures++;
            $display("FAIL spur_status status=%h vec=%0d in_service=%b required valid=0 vec=%0d insvc=1", d, vec, in_service, e);
        end
        wr_reg(3'd3, 32'h0);
    endtask

    task automatic test_ovf();
        logic [31:0] d;
        wr_reg(3'd0, 32'h00);
        wr_reg(3'd2, 32'h40);
        pulse(6); tick(); tick();
        pulse(6); tick(); tick();
        rd_reg(3'd4, d);
        checks++;
        if (d !== EXP_OVF) begin failures++; $display("FAIL ovf_set got=%h required=%h", d, EXP_OVF); end
        wr_reg(3'd4, 32'h40);
        rd_reg(3'd4, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL ovf_clear got=%h required=0", d); end
        rd_reg(3'd1, d);
        checks++;
        if (d !== 32'h40) begin failures++; $display("FAIL ovf_pending got=%h required=40", d); end
        wr_reg(3'd1, 32'h40);
    endtask

    task automatic test_rst_mid();
        logic [31:0] d;
        logic [2:0]  e;
        bit ok;
        wr_reg(3'd2, 32'h08);
        wr_reg(3'd0, 32'h08);
        sb_q.push_back(3'd3);
        pulse(3);
        wait_irq(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rst_wait irq=%b required=1", irq); end
        do_ack();
        e = sb_q.pop_front();
        checks++;
        if (vec !== e || in_service !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre vec=%0d in_service=%b required %0d/1", vec, in_service, e);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (irq !== 1'b0 || in_service !== 1'b0 || vec !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs irq=%b in_service=%b vec=%0d required 0/0/0", irq, in_service, vec);
        end
        for (int a = 0; a < 5; a++) begin
            rd_reg(3'(a), d);
            checks++;
            if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_reg%0d got=%h required=0", a, d); end
        end
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; int_ack = 1'b0; rti = 1'b0;
        rd = 1'b0; wr = 1'b0; adr = '0; wdata = '0;
        test_reset();
        test_edge_basic();
        test_priority();
        test_level();
        test_spurious();
        test_ovf();
        test_rst_mid();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
